// File: rtl/mult_pkg.sv
// Shared constants and state encoding for the Booth multiplier.
// No logic of its own; imported by mult_unit and booth_step.
// Widths are fixed: 32-bit operands, 33-bit accumulator, 66-bit P register.
package mult_pkg;

    localparam int WORD_W = 32;
    localparam int ACC_W  = 33;
    localparam int P_W    = 66;
    localparam int STEPS  = 32;
    localparam int CNT_W  = 6;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_t;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth step: recode P[1:0], add/sub M into the upper 33 bits, then arithmetic shift right.
// Purely combinational, zero latency.
// No handshake; the caller decides when to register the result.
module booth_step
    import mult_pkg::*;
(
    input  logic [P_W-1:0]   p_i,
    input  logic [ACC_W-1:0] m_i,
    output logic [P_W-1:0]   p_o
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;

    // Recode the low pair, update the accumulator, and shift in its sign bit
    always_comb begin
        acc = p_i[P_W-1:WORD_W+1];
        sum = acc;
        case (p_i[1:0])
            2'b01:   sum = acc + m_i;
            2'b10:   sum = acc - m_i;
            default: sum = acc;
        endcase
        p_o = {sum[ACC_W-1], sum, p_i[WORD_W:1]};
    end

endmodule

// File: rtl/mult_unit.sv
// Multicycle signed 32x32 Booth multiplier producing hi/lo for MULT.
// Latency 33 cycles from the start edge; one operation per 34 cycles.
// multOP is ignored while busy or finishing; a running operation is never restarted.
module mult_unit
    import mult_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              multOP,
    input  logic [WORD_W-1:0] A,
    input  logic [WORD_W-1:0] B,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] hi,
    output logic [WORD_W-1:0] lo
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [P_W-1:0]     p_q, p_d;
    logic [ACC_W-1:0]   m_q, m_d;
    logic [WORD_W-1:0]  hi_q, hi_d;
    logic [WORD_W-1:0]  lo_q, lo_d;
    logic               done_q, done_d;
    logic [P_W-1:0]     p_step;

    booth_step u_booth_step (
        .p_i (p_q),
        .m_i (m_q),
        .p_o (p_step)
    );

    // Next-state and datapath control; everything holds unless the state says otherwise
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        m_d     = m_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (multOP) begin
                    // 33-bit multiplicand so that negating 0x80000000 cannot overflow
                    m_d     = {A[WORD_W-1], A};
                    p_d     = {{ACC_W{1'b0}}, B, 1'b0};
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                p_d   = p_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(STEPS - 1)) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                // P[65] is only a sign duplicate; the product sits in P[64:1]
                hi_d    = p_q[2*WORD_W:WORD_W+1];
                lo_d    = p_q[WORD_W:1];
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously so an aborted op leaves no trace
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            p_q     <= '0;
            m_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            m_q     <= m_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    // done is only set on the way back to IDLE, so it never overlaps busy
    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_unit.sv
// Directed-vector bench for mult_unit with hand-computed products.
// Inputs driven and outputs sampled on the falling edge of clk.
// Every wait on the DUT is bounded by a fixed cycle budget.
module tb_mult_unit;

    logic        clk;
    logic        reset;
    logic        multOP;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks   = 0;
    int failures = 0;

    mult_unit dut (
        .clk    (clk),
        .reset  (reset),
        .multOP (multOP),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Start one operation at edge N and track it to completion.
    // Sample k is the falling edge after edge N+k. inject_k>0 pulses multOP
    // with A=2,B=9 so that it is high at edge N+inject_k.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input int inject_k);
        int done_k;
        int busy_cnt;
        int overlap;
        done_k   = 0;
        busy_cnt = 0;
        overlap  = 0;
        @(negedge clk);
        A      = a;
        B      = b;
        multOP = 1'b1;
        @(negedge clk);
        multOP = 1'b0;
        // Operands are sampled once; scramble them afterwards
        A = 32'h1234_5678;
        B = 32'h9ABC_DEF0;
        chk({tag, "_busy_start"}, {63'b0, busy}, 64'd1);
        if (busy) busy_cnt++;
        for (int k = 1; k <= 40 && done_k == 0; k++) begin
            if (inject_k > 0 && k == inject_k) begin
                A      = 32'd2;
                B      = 32'd9;
                multOP = 1'b1;
            end
            @(negedge clk);
            if (inject_k > 0 && k == inject_k) multOP = 1'b0;
            if (busy && done) overlap++;
            if (busy) busy_cnt++;
            if (done) done_k = k;
            else if (done_k == 0 && (hi !== 32'hDEAD_BEEF) && k < 33 && tag == "held") overlap++;
        end
        chk({tag, "_latency"}, 64'(done_k), 64'd33);
        chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
        chk({tag, "_overlap"}, 64'(overlap), 64'd0);
        chk({tag, "_product"}, {hi, lo}, {exp_hi, exp_lo});
        @(negedge clk);
        chk({tag, "_done_drop"}, {63'b0, done}, 64'd0);
        chk({tag, "_idle"}, {63'b0, busy}, 64'd0);
    endtask

    initial begin
        int last_k;
        int pulses;
        logic [31:0] old_hi;
        logic [31:0] old_lo;

        reset  = 1'b1;
        multOP = 1'b0;
        A      = '0;
        B      = '0;
        repeat (3) @(negedge clk);
        chk("rst_hi",   {32'b0, hi}, 64'd0);
        chk("rst_lo",   {32'b0, lo}, 64'd0);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_done", {63'b0, done}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op("3x5",     32'd3,         32'd5,         32'h0000_0000, 32'h0000_000F, 0);
        run_op("m7x6",    32'hFFFF_FFF9, 32'd6,         32'hFFFF_FFFF, 32'hFFFF_FFD6, 0);
        run_op("minxmin", 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 0);
        run_op("maxxmax", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 0);
        run_op("m1xm1",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 10);
        run_op("m5x7",    32'hFFFF_FFFB, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFDD, 0);

        // hi/lo must hold the previous product until the next FINISH edge
        @(negedge clk);
        A = 32'd100;
        B = 32'd100;
        multOP = 1'b1;
        @(negedge clk);
        multOP = 1'b0;
        repeat (14) @(negedge clk);
        chk("hold_hi", {32'b0, hi}, 64'hFFFF_FFFF);
        chk("hold_lo", {32'b0, lo}, 64'hFFFF_FFDD);
        // Asynchronous reset mid-RUN
        #2 reset = 1'b1;
        #1;
        chk("arst_hi",   {32'b0, hi}, 64'd0);
        chk("arst_lo",   {32'b0, lo}, 64'd0);
        chk("arst_busy", {63'b0, busy}, 64'd0);
        chk("arst_done", {63'b0, done}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        // No late done from the aborted operation
        pulses = 0;
        repeat (30) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        chk("arst_no_done", 64'(pulses), 64'd0);
        run_op("100x100", 32'd100, 32'd100, 32'h0000_0000, 32'h0000_2710, 0);

        // multOP held high: a done pulse every 34 cycles
        @(negedge clk);
        A      = 32'd1;
        B      = 32'hFFFF_FFFF;
        multOP = 1'b1;
        last_k = 0;
        pulses = 0;
        for (int k = 1; k <= 150 && pulses < 3; k++) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                old_hi = hi;
                old_lo = lo;
                chk("b2b_product", {old_hi, old_lo}, 64'hFFFF_FFFF_FFFF_FFFF);
                chk("b2b_busy", {63'b0, busy}, 64'd0);
                if (last_k != 0) chk("b2b_period", 64'(k - last_k), 64'd34);
                last_k = k;
            end
        end
        chk("b2b_pulses", 64'(pulses), 64'd3);
        multOP = 1'b0;
        repeat (40) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
